// File: rtl/axi_slave_mem_responder_pkg.sv
// Shared AXI encodings, FSM states and burst-error decode for the memory responder.
package axi_slave_mem_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_8B = 3'b011;

  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // DECERR outranks SLVERR so an unmapped address never touches the array.
  function automatic logic [1:0] burst_resp(input logic in_range, input logic [2:0] size,
                                            input logic [1:0] burst);
    if (!in_range) return RESP_DECERR;
    if (size != SIZE_8B || burst == BURST_WRAP) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_slave_mem_responder_array.sv
// Word array: one registered read port, one byte-strobed write port, read-first.
// Latency: read data valid the cycle after rd_en; writes land at the clock edge.
// Backpressure: none, rd_dat holds its value while rd_en is low.
module axi_slave_mem_array #(
  parameter int MEM_ADDR_W = 10,
  parameter int DATA_W     = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rd_en,
  input  logic [MEM_ADDR_W-1:0] rd_idx,
  output logic [DATA_W-1:0]     rd_dat,
  input  logic                  wr_en,
  input  logic [MEM_ADDR_W-1:0] wr_idx,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic [DATA_W-1:0]     wr_dat
);

  logic [DATA_W-1:0] mem [2**MEM_ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (wr_strb[i]) mem[wr_idx][i*8 +: 8] <= wr_dat[i*8 +: 8];
      end
    end
  end

  // Contents survive reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (!resetn)    rd_dat <= '0;
    else if (rd_en) rd_dat <= mem[rd_idx];
  end

endmodule

// File: rtl/axi_slave_mem_responder.sv
// AXI3 memory responder with independent read and write burst engines.
// Latency: first R beat one cycle after AR; B one cycle after the final W beat.
// Backpressure: R and B hold while RREADY/BREADY low; W stalled until AW accepted.
module axi_slave_mem_responder
  import axi_slave_mem_responder_pkg::*;
#(
  parameter int               ADDR_W     = 32,
  parameter int               DATA_W     = 64,
  parameter int               ID_W       = 6,
  parameter int               MEM_ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [ID_W-1:0]     S_AXI_AWID,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic [3:0]          S_AXI_AWLEN,
  input  logic [2:0]          S_AXI_AWSIZE,
  input  logic [1:0]          S_AXI_AWBURST,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [ID_W-1:0]     S_AXI_WID,
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WLAST,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [ID_W-1:0]     S_AXI_BID,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ID_W-1:0]     S_AXI_ARID,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic [3:0]          S_AXI_ARLEN,
  input  logic [2:0]          S_AXI_ARSIZE,
  input  logic [1:0]          S_AXI_ARBURST,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [ID_W-1:0]     S_AXI_RID,
  output logic [DATA_W-1:0]   S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RLAST,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  output logic [31:0]         rd_burst_count,
  output logic [31:0]         wr_burst_count
);

  localparam logic [ADDR_W-1:0]     MEM_BYTES = ADDR_W'(1) << (MEM_ADDR_W + 3);
  localparam logic [MEM_ADDR_W-1:0] IDX_ONE   = MEM_ADDR_W'(1);

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [MEM_ADDR_W-1:0] idx;
    logic [3:0]            len;
    logic                  fixed;
    logic [1:0]            resp;
  } burst_t;

  function automatic burst_t decode(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                                    input logic [3:0] len, input logic [2:0] size,
                                    input logic [1:0] burst);
    logic [ADDR_W-1:0] off;
    burst_t b;
    off     = addr - BASE_ADDR;
    b.id    = id;
    b.idx   = off[MEM_ADDR_W+2:3];
    b.len   = len;
    b.fixed = (burst == BURST_FIXED);
    b.resp  = burst_resp(off < MEM_BYTES, size, burst);
    return b;
  endfunction

  burst_t                ar_dec, aw_dec, r_cur, w_cur;
  r_state_t              r_state, r_state_nxt;
  w_state_t              w_state, w_state_nxt;
  logic [3:0]            r_beat, w_beat;
  logic                  ar_hs, r_hs, r_last, aw_hs, w_hs, b_hs, w_last, w_bad, w_drop;
  logic                  rd_en;
  logic [MEM_ADDR_W-1:0] rd_idx, r_idx_nxt, w_idx_nxt;
  logic [DATA_W-1:0]     rd_dat;

  assign ar_dec = decode(S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST);
  assign aw_dec = decode(S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST);

  // ---------------- read engine ----------------
  assign r_last    = (r_beat == r_cur.len);
  assign r_idx_nxt = r_cur.fixed ? r_cur.idx : r_cur.idx + IDX_ONE;
  assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs      = S_AXI_RVALID && S_AXI_RREADY;

  always_comb begin
    r_state_nxt   = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    rd_en         = 1'b0;
    rd_idx        = r_idx_nxt;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = resetn;
        if (S_AXI_ARVALID && resetn) begin
          rd_en       = 1'b1;
          rd_idx      = ar_dec.idx;
          r_state_nxt = R_BURST;
        end
      end
      R_BURST: begin
        S_AXI_RVALID = resetn;
        if (S_AXI_RREADY && resetn) begin
          if (r_last) r_state_nxt = R_IDLE;
          else        rd_en       = 1'b1;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= R_IDLE;
    else         r_state <= r_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cur          <= '0;
      r_beat         <= '0;
      rd_burst_count <= '0;
    end else if (ar_hs) begin
      r_cur  <= ar_dec;
      r_beat <= '0;
    end else if (r_hs) begin
      if (r_last) begin
        rd_burst_count <= rd_burst_count + 32'd1;
      end else begin
        r_beat    <= r_beat + 4'd1;
        r_cur.idx <= r_idx_nxt;
      end
    end
  end

  assign S_AXI_RID   = r_cur.id;
  assign S_AXI_RRESP = r_cur.resp;
  assign S_AXI_RLAST = S_AXI_RVALID && r_last;
  assign S_AXI_RDATA = (r_cur.resp == RESP_DECERR) ? '0 : rd_dat;

  // ---------------- write engine ----------------
  assign w_last    = (w_beat == w_cur.len);
  assign w_bad     = (S_AXI_WLAST != w_last) || (S_AXI_WID != w_cur.id);
  assign w_idx_nxt = w_cur.fixed ? w_cur.idx : w_cur.idx + IDX_ONE;
  assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs      = S_AXI_BVALID && S_AXI_BREADY;

  always_comb begin
    w_state_nxt   = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = resetn;
        if (S_AXI_AWVALID && resetn) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        S_AXI_WREADY = resetn;
        // Beat count, not WLAST, ends the burst.
        if (S_AXI_WVALID && resetn && w_last) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = resetn;
        if (S_AXI_BREADY && resetn) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) w_state <= W_IDLE;
    else         w_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_cur          <= '0;
      w_beat         <= '0;
      w_drop         <= 1'b0;
      wr_burst_count <= '0;
    end else begin
      if (aw_hs) begin
        w_cur  <= aw_dec;
        w_beat <= '0;
        w_drop <= (aw_dec.resp != RESP_OKAY);
      end
      if (w_hs) begin
        w_beat    <= w_beat + 4'd1;
        w_cur.idx <= w_idx_nxt;
        if (w_bad && w_cur.resp == RESP_OKAY) w_cur.resp <= RESP_SLVERR;
      end
      if (b_hs) wr_burst_count <= wr_burst_count + 32'd1;
    end
  end

  assign S_AXI_BID   = w_cur.id;
  assign S_AXI_BRESP = w_cur.resp;

  axi_slave_mem_array #(
    .MEM_ADDR_W (MEM_ADDR_W),
    .DATA_W     (DATA_W)
  ) u_array (
    .clk     (clk),
    .resetn  (resetn),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_dat  (rd_dat),
    .wr_en   (w_hs && !w_drop),
    .wr_idx  (w_cur.idx),
    .wr_strb (S_AXI_WSTRB),
    .wr_dat  (S_AXI_WDATA)
  );

endmodule
